// File: rtl/uart_rx_fifo_interface.sv
// rtl/uart_rx_fifo_interface.sv - FWFT receive buffer between UART RX and the consumer, with EOT tracking and sticky overrun
module uart_rx_fifo_interface #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] EOT_CHAR   = 8'h04,
    localparam int                   AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_flag,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear_flag,
    input  logic                  flush,
    input  logic                  overrun_clr,
    output logic                  flag,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  eot_pending,
    output logic                  head_is_eot,
    output logic                  overrun
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   eot_cnt_q, eot_cnt_d;
    logic          overrun_q, overrun_d;

    logic push, pop, drop, push_eot, pop_eot;

    assign flag        = (count_q != '0);
    assign full        = (count_q == FULL_CNT);
    assign count       = count_q;
    assign eot_pending = (eot_cnt_q != '0);
    assign overrun     = overrun_q;
    assign data_out    = flag ? mem[rd_ptr_q] : '0;
    assign head_is_eot = flag && (mem[rd_ptr_q] == EOT_CHAR);

    // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
    assign pop      = clear_flag && flag;
    assign push     = set_flag && (!full || pop);
    assign drop     = set_flag && full && !pop && !flush;
    assign push_eot = push && (data_in == EOT_CHAR);
    assign pop_eot  = pop && head_is_eot;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        eot_cnt_d = eot_cnt_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            eot_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            case ({push_eot, pop_eot})
                2'b10:   eot_cnt_d = eot_cnt_q + (AW+1)'(1);
                2'b01:   eot_cnt_d = eot_cnt_q - (AW+1)'(1);
                default: eot_cnt_d = eot_cnt_q;
            endcase
        end
    end

    // Setting wins over clearing so a drop in the clear cycle is never lost.
    always_comb begin
        overrun_d = overrun_q;
        if (drop)             overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            eot_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            eot_cnt_q <= eot_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= data_in;
    end

endmodule
